ids_dma: RTL and testbench
==========================

IDS_DMA -- requirements
Module: ids_dma

Interface
REQ-001 Parameter LEN_W, default 16: width of the transfer word count.
REQ-002 i_clk  input  1  sole clock; all logic rising-edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_start  input  1  one-cycle command strobe; sampled only in IDLE.
REQ-005 i_src_addr  input  32  source byte address, captured on accepted i_start.
REQ-006 i_dst_addr  input  32  destination byte address, captured on accepted i_start.
REQ-007 i_len  input  LEN_W  number of 32-bit words to copy, captured on accepted i_start.
REQ-008 o_busy  output  1  high in every state except IDLE.
REQ-009 o_done  output  1  one-cycle pulse at normal transfer completion.
REQ-010 o_req_dma  output  1  bus request to the DMEM-side arbiter.
REQ-011 i_gnt_dma  input  1  bus grant; may drop on any cycle because the core has priority.
REQ-012 o_dma_addr  output  32  bus address, bits [1:0] always 0.
REQ-013 o_dma_read / o_dma_write  output  1 each  bus read and write strobes, never high together.
REQ-014 o_dma_size  output  4  byte mask, constant 4'b1111.
REQ-015 o_dma_din  output  32  write data.
REQ-016 i_dma_dout  input  32  read data, valid the cycle after a granted read.

Function
REQ-017 The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT, WR_REQ and DONE.
REQ-018 IDLE: on i_start with i_len!=0, latch src, dst and len (address bits [1:0] cleared) and go to RD_REQ; with i_len==0, go to DONE without any bus activity.
REQ-019 RD_REQ: drive o_req_dma=1, o_dma_read=1 and o_dma_addr=src; stay until i_gnt_dma=1 in the same cycle, then go to RD_WAIT.
REQ-020 RD_WAIT: drive o_req_dma=0; capture i_dma_dout into the data register; go to WR_REQ.
REQ-021 WR_REQ: drive o_req_dma=1, o_dma_write=1, o_dma_addr=dst and o_dma_din=data register; stay until i_gnt_dma=1.
REQ-022 On a granted write: src+=4 and dst+=4 (mod 2^32, wrap permitted); remaining-=1; if remaining was 1, go to DONE, otherwise go to RD_REQ.
REQ-023 DONE: drive o_done=1 for exactly one cycle, then go to IDLE.
REQ-024 Outside RD_REQ and WR_REQ, o_req_dma, o_dma_read and o_dma_write SHALL be 0.
REQ-025 Withdrawn grant: while in RD_REQ or WR_REQ, hold the request and all bus outputs stable until the grant arrives; no timeout.
REQ-026 Throughput: at best 3 cycles per word (RD_REQ, RD_WAIT, WR_REQ).
REQ-027 i_start outside IDLE SHALL be ignored and SHALL NOT disturb the latched registers.
REQ-028 Overlapping source and destination regions are copied in ascending address order with no hazard protection.

Reset
REQ-029 With i_rst=1 at a clock edge: state goes to IDLE; o_busy=0, o_done=0, o_req_dma=0, o_dma_read=0, o_dma_write=0, o_dma_addr=0, o_dma_din=0; address, count and data registers are cleared.
REQ-030 Reset in the middle of a transfer aborts it with no o_done pulse; bus outputs are low in the cycle after the reset edge.

Configuration
REQ-031 Macro IDS_DMA_ABORT_EN, when defined, adds an input i_abort (1 bit).
REQ-032 With IDS_DMA_ABORT_EN: i_abort=1 in any non-IDLE state forces IDLE on the next edge with no o_done pulse; a write already granted in that cycle completes; i_abort has priority over state transitions.
REQ-033 Without IDS_DMA_ABORT_EN: the i_abort port and its logic are absent.

Verification
REQ-034 src=0x100, dst=0x200, len=4, i_gnt_dma tied 1 -> 4 reads then 4 writes interleaved to 0x100..0x10C and 0x200..0x20C; o_done at cycle 14 after i_start; data matches.
REQ-035 len=0 -> no o_req_dma; o_done pulses 1 cycle after i_start; o_busy high for 1 cycle.
REQ-036 len=2, i_gnt_dma low for 5 cycles during the first RD_REQ -> addr, read and req stay stable; the copy completes correctly 5 cycles later.
REQ-037 src=0xFFFFFFFC, len=2 -> second read address is 0x00000000.
REQ-038 i_rst pulsed during WR_REQ of word 3 of 8 -> outputs are 0 the next cycle, no o_done; a new i_start then runs normally.
REQ-039 (IDS_DMA_ABORT_EN) i_abort during RD_WAIT -> IDLE the next cycle, no write issued, no o_done.

Source files
------------

// File: rtl/ids_dma_if.sv
// ids_dma_if -- command and DMEM-side bus bundle for the ids_dma word-copy engine.
//
// Signal groups:
//   command : i_start, i_src_addr, i_dst_addr, i_len   (environment -> DMA)
//   status  : o_busy, o_done                          (DMA -> environment)
//   bus     : o_req_dma, o_dma_addr, o_dma_read, o_dma_write, o_dma_size,
//             o_dma_din (DMA -> arbiter/memory); i_gnt_dma, i_dma_dout
//             (arbiter/memory -> DMA)
//
// Modports:
//   master : the DMA engine side (drives status and bus request/strobes)
//   slave  : the environment side (drives command, grant and read data)
interface ids_dma_if #(
    parameter int LEN_W = 16
);
    logic             i_start;
    logic [31:0]      i_src_addr;
    logic [31:0]      i_dst_addr;
    logic [LEN_W-1:0] i_len;
    logic             o_busy;
    logic             o_done;
    logic             o_req_dma;
    logic             i_gnt_dma;
    logic [31:0]      o_dma_addr;
    logic             o_dma_read;
    logic             o_dma_write;
    logic [3:0]       o_dma_size;
    logic [31:0]      o_dma_din;
    logic [31:0]      i_dma_dout;

    modport master (
        input  i_start, i_src_addr, i_dst_addr, i_len, i_gnt_dma, i_dma_dout,
        output o_busy, o_done, o_req_dma, o_dma_addr, o_dma_read, o_dma_write,
               o_dma_size, o_dma_din
    );

    modport slave (
        output i_start, i_src_addr, i_dst_addr, i_len, i_gnt_dma, i_dma_dout,
        input  o_busy, o_done, o_req_dma, o_dma_addr, o_dma_read, o_dma_write,
               o_dma_size, o_dma_din
    );
endinterface

// File: rtl/ids_dma.sv
// ids_dma -- single-channel word-copy DMA engine on a shared DMEM port.
//
// Copies i_len 32-bit words from i_src_addr to i_dst_addr in ascending order,
// one read followed by one write per word (3 cycles per word at best). The bus
// grant can be withdrawn on any cycle; the request and all bus outputs are held
// until it returns.
//
// Ports:
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset
//   i_abort  : (only with IDS_DMA_ABORT_EN) return to IDLE without o_done
//   bus      : ids_dma_if.master -- command, status and DMEM bus signals
//
// Configuration macro: IDS_DMA_ABORT_EN adds the i_abort input.
//
// State table:
//   IDLE    | waiting for i_start
//   RD_REQ  | requesting bus, read strobe at source address
//   RD_WAIT | capturing read data returned by memory
//   WR_REQ  | requesting bus, write strobe at destination address
//   DONE    | one-cycle o_done pulse
module ids_dma #(
    parameter int LEN_W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
`ifdef IDS_DMA_ABORT_EN
    input  logic         i_abort,
`endif
    ids_dma_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      data_q, data_d;

    logic             req;
    logic             rd;
    logic             wr;
    logic             done;
    logic [31:0]      addr;
    logic [31:0]      din;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        data_d  = data_q;
        req     = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        done    = 1'b0;
        addr    = '0;
        din     = '0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_len != '0) begin
                        // Word-aligned addresses only; low bits are dropped here
                        // so the increment path never has to mask them.
                        src_d   = {bus.i_src_addr[31:2], 2'b00};
                        dst_d   = {bus.i_dst_addr[31:2], 2'b00};
                        len_d   = bus.i_len;
                        state_d = RD_REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RD_REQ: begin
                req  = 1'b1;
                rd   = 1'b1;
                addr = src_q;
                if (bus.i_gnt_dma) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                data_d  = bus.i_dma_dout;
                state_d = WR_REQ;
            end
            WR_REQ: begin
                req  = 1'b1;
                wr   = 1'b1;
                addr = dst_q;
                din  = data_q;
                if (bus.i_gnt_dma) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    len_d   = len_q - LEN_W'(1);
                    state_d = (len_q == LEN_W'(1)) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef IDS_DMA_ABORT_EN
        // Abort overrides the next state only; a write granted this cycle has
        // already happened on the bus.
        if (i_abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
`endif
    end

    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_done      = done;
    assign bus.o_req_dma   = req;
    assign bus.o_dma_read  = rd;
    assign bus.o_dma_write = wr;
    assign bus.o_dma_addr  = addr;
    assign bus.o_dma_din   = din;
    assign bus.o_dma_size  = 4'b1111;

endmodule

// File: tb/tb_ids_dma.sv
// tb_ids_dma -- self-checking bench for ids_dma.
// A word-addressed memory model answers the bus; the expected transaction
// sequence and final memory image come from a sequential copy model.
module tb_ids_dma;

    logic clk;
    logic rst;
`ifdef IDS_DMA_ABORT_EN
    logic abort;
`endif

    ids_dma_if #(.LEN_W(16)) bus ();

    ids_dma #(.LEN_W(16)) dut (
        .i_clk(clk),
        .i_rst(rst),
`ifdef IDS_DMA_ABORT_EN
        .i_abort(abort),
`endif
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          hold;
        int          lat;
        logic [31:0] last_rd;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [31:0]];
    txn_t        expq [$];

    int          cyc = 0;
    bit          rd_pend = 0;
    logic [31:0] rd_addr = '0;
    int          hold_cnt = 0;
    bit          rand_gnt = 0;
    int          stall_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          busy_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rd = '0;
    bit          prev_stall = 0;
    logic [31:0] p_addr, p_din;
    logic        p_rd, p_wr;
    int          rst_at_wr = 0;
    bit          rst_fired = 0;
    bit          abort_arm = 0;
    bit          abort_fired = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h005A};
    endfunction

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    // One clock cycle: memory/arbiter response plus bus monitor, at the negedge.
    task automatic step();
        logic g;
        bit   was_rd;
        txn_t t;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
`ifdef IDS_DMA_ABORT_EN
        abort = 1'b0;
`endif
        if (rd_pend) begin
            bus.i_dma_dout = memrd(rd_addr);
            rd_pend = 0;
            was_rd = 1;
        end else begin
            bus.i_dma_dout = $urandom;
            was_rd = 0;
        end

        if (bus.o_req_dma || bus.o_dma_read || bus.o_dma_write) begin
            chk("strobe_excl", 32'(bus.o_dma_read & bus.o_dma_write), 32'd0);
            chk("req_vs_strobe", 32'(bus.o_req_dma), 32'(bus.o_dma_read | bus.o_dma_write));
            chk("addr_align", 32'(bus.o_dma_addr[1:0]), 32'd0);
            chk("size_mask", 32'(bus.o_dma_size), 32'hF);
        end
        if (prev_stall) begin
            chk("hold_req", 32'(bus.o_req_dma), 32'd1);
            chk("hold_addr", bus.o_dma_addr, p_addr);
            chk("hold_rd", 32'(bus.o_dma_read), 32'(p_rd));
            chk("hold_wr", 32'(bus.o_dma_write), 32'(p_wr));
            chk("hold_din", bus.o_dma_din, p_din);
        end
        if (bus.o_busy) busy_cnt++;
        if (bus.o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end

        if (bus.o_req_dma && hold_cnt > 0) begin
            g = 1'b0;
            hold_cnt--;
        end else if (rand_gnt) begin
            g = ($urandom_range(0, 3) != 0);
        end else begin
            g = 1'b1;
        end
        bus.i_gnt_dma = g;

        prev_stall = bus.o_req_dma && !g;
        p_addr = bus.o_dma_addr;
        p_din  = bus.o_dma_din;
        p_rd   = bus.o_dma_read;
        p_wr   = bus.o_dma_write;
        if (bus.o_req_dma && !g) stall_cnt++;

        if (bus.o_req_dma && g) begin
            chk("txn_pending", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                t = expq.pop_front();
                chk("txn_kind", 32'(bus.o_dma_write), 32'(t.wr));
                chk("txn_addr", bus.o_dma_addr, t.addr);
                if (t.wr) chk("wr_data", bus.o_dma_din, t.data);
            end
            if (bus.o_dma_read) begin
                rd_pend = 1;
                rd_addr = bus.o_dma_addr;
                last_rd = bus.o_dma_addr;
            end
            if (bus.o_dma_write) begin
                mem[bus.o_dma_addr] = bus.o_dma_din;
                wr_cnt++;
                if (rst_at_wr != 0 && wr_cnt == rst_at_wr) begin
                    rst = 1'b1;
                    rst_fired = 1;
                end
            end
        end
`ifdef IDS_DMA_ABORT_EN
        if (abort_arm && was_rd) begin
            abort = 1'b1;
            abort_arm = 0;
            abort_fired = 1;
        end
`endif
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
        chk({tag, "_req"}, 32'(bus.o_req_dma), 32'd0);
        chk({tag, "_rd"}, 32'(bus.o_dma_read), 32'd0);
        chk({tag, "_wr"}, 32'(bus.o_dma_write), 32'd0);
        chk({tag, "_addr"}, bus.o_dma_addr, 32'd0);
        chk({tag, "_din"}, bus.o_dma_din, 32'd0);
    endtask

    // mode 0: normal copy; 1: reset on the rst_at_wr-th granted write; 2: abort in RD_WAIT
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input int exp_lat,
                            input logic [31:0] exp_last, input int mode, input bit noise);
        logic [31:0] m [logic [31:0]];
        logic [31:0] sa, da, s, d, w;
        int c0, done0, lat, n;
        txn_t t;
        sa = {src[31:2], 2'b00};
        da = {dst[31:2], 2'b00};
        m = mem;
        expq.delete();
        for (int i = 0; i < int'(len); i++) begin
            s = sa + 32'(4 * i);
            d = da + 32'(4 * i);
            w = m.exists(s) ? m[s] : init_word(s);
            t.wr = 0; t.addr = s; t.data = '0; expq.push_back(t);
            t.wr = 1; t.addr = d; t.data = w;  expq.push_back(t);
            m[d] = w;
        end
        stall_cnt = 0; busy_cnt = 0; wr_cnt = 0;
        done0 = done_cnt;
        c0 = cyc;
        bus.i_start = 1'b1;
        bus.i_src_addr = src;
        bus.i_dst_addr = dst;
        bus.i_len = len;
        step();
        n = 0;
        while (done_cnt == done0 && !rst_fired && !abort_fired && n < 400) begin
            bus.i_start = noise && bus.o_busy && ($urandom_range(0, 3) == 0);
            bus.i_src_addr = $urandom;
            bus.i_dst_addr = $urandom;
            bus.i_len = 16'($urandom_range(1, 9));
            step();
            n++;
        end
        bus.i_start = 1'b0;

        if (mode == 0) begin
            lat = (exp_lat >= 0) ? exp_lat : ((len == 0) ? 1 : 3 * int'(len) + 1 + stall_cnt);
            chk("done_count", 32'(done_cnt - done0), 32'd1);
            chk("done_latency", 32'(done_cyc - c0), 32'(lat));
            chk("busy_cycles", 32'(busy_cnt), 32'(lat));
            chk("txn_left", 32'(expq.size()), 32'd0);
            if (len != 0) chk("last_rd_addr", last_rd, exp_last);
            step();
            step();
            chk("after_idle", 32'(bus.o_busy), 32'd0);
            chk("single_done", 32'(done_cnt - done0), 32'd1);
            for (int i = 0; i < int'(len); i++) begin
                d = da + 32'(4 * i);
                chk("mem_image", memrd(d), m[d]);
            end
        end else if (mode == 1) begin
            chk("rst_reached", 32'(rst_fired), 32'd1);
            step();
            chk_quiet("post_rst");
            repeat (4) step();
            chk("rst_no_done", 32'(done_cnt - done0), 32'd0);
            rst_fired = 0;
            rst_at_wr = 0;
        end else begin
            chk("abort_reached", 32'(abort_fired), 32'd1);
            step();
            chk("abort_busy", 32'(bus.o_busy), 32'd0);
            chk("abort_req", 32'(bus.o_req_dma), 32'd0);
            repeat (4) step();
            chk("abort_no_wr", 32'(wr_cnt), 32'd0);
            chk("abort_no_done", 32'(done_cnt - done0), 32'd0);
            abort_fired = 0;
        end
        expq.delete();
        rd_pend = 0;
    endtask

    vec_t vecs [6];

    initial begin
        // DONE lands 3*len+1 cycles after the start cycle (the 14th cycle for
        // len=4 when the start cycle is counted as the first), plus stalls.
        vecs[0] = '{src: 32'h0000_0100, dst: 32'h0000_0200, len: 16'd4, hold: 0, lat: 13, last_rd: 32'h0000_010C};
        vecs[1] = '{src: 32'h0000_0100, dst: 32'h0000_0200, len: 16'd0, hold: 0, lat: 1,  last_rd: 32'h0};
        vecs[2] = '{src: 32'h0000_0300, dst: 32'h0000_0400, len: 16'd2, hold: 5, lat: 12, last_rd: 32'h0000_0304};
        vecs[3] = '{src: 32'hFFFF_FFFC, dst: 32'h0000_0500, len: 16'd2, hold: 0, lat: 7,  last_rd: 32'h0000_0000};
        vecs[4] = '{src: 32'h0000_0103, dst: 32'h0000_0602, len: 16'd1, hold: 0, lat: 4,  last_rd: 32'h0000_0100};
        vecs[5] = '{src: 32'h0000_0700, dst: 32'h0000_0704, len: 16'd3, hold: 0, lat: 10, last_rd: 32'h0000_0708};

        rst = 1'b1;
`ifdef IDS_DMA_ABORT_EN
        abort = 1'b0;
`endif
        bus.i_start = 1'b0;
        bus.i_src_addr = '0;
        bus.i_dst_addr = '0;
        bus.i_len = '0;
        bus.i_gnt_dma = 1'b0;
        bus.i_dma_dout = '0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        chk("reset_size", 32'(bus.o_dma_size), 32'hF);
        step();

        rand_gnt = 0;
        for (int v = 0; v < 6; v++) begin
            hold_cnt = vecs[v].hold;
            run_xfer(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].lat, vecs[v].last_rd, 0, 0);
        end

        // Reset during the write of word 3 of 8, then a normal copy.
        rst_at_wr = 3;
        run_xfer(32'h0000_0800, 32'h0000_0900, 16'd8, -1, 32'h0, 1, 0);
        run_xfer(32'h0000_0A00, 32'h0000_0B00, 16'd3, 10, 32'h0000_0A08, 0, 0);

`ifdef IDS_DMA_ABORT_EN
        abort_arm = 1;
        run_xfer(32'h0000_0C00, 32'h0000_0D00, 16'd4, -1, 32'h0, 2, 0);
`endif

        // Randomized copies with random grant, ignored starts and overlap.
        rand_gnt = 1;
        for (int r = 0; r < 25; r++) begin
            logic [31:0] s, d;
            logic [15:0] l;
            s = 32'h0000_1000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            d = 32'h0000_1000 + 32'($urandom_range(0, 31) * 4);
            l = 16'($urandom_range(0, 6));
            run_xfer(s, d, l, -1, s[31:2] * 4 + 32'(4 * (int'(l) - 1)), 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
